// File: rtl/sram_bus_ctrl_pkg.sv
// sram_bus_ctrl_pkg: shared state encoding and strobe constants for the SRAM bus controller
package sram_bus_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  typedef struct packed {
    logic cs;
    logic oe;
    logic we;
  } strobe_t;
  localparam strobe_t STROBE_IDLE = 3'b111;
endpackage

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: valid/ready request port to asynchronous SRAM bus cycles with registered active-low strobes
module sram_bus_ctrl
  import sram_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int RD_WAIT_CYCLES  = 2,
  parameter int WR_PULSE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_notCS,
  output logic                  sram_notOE,
  output logic                  sram_notWE
);
  localparam int MW = RD_WAIT_CYCLES > WR_PULSE_CYCLES ? RD_WAIT_CYCLES : WR_PULSE_CYCLES;
  localparam int CW = $clog2(MW + 1);
  if (RD_WAIT_CYCLES < 1 || WR_PULSE_CYCLES < 1) begin : g_bad_param
    $error("sram_bus_ctrl: RD_WAIT_CYCLES and WR_PULSE_CYCLES must be >= 1");
  end
  state_t          state, nstate;
  logic [CW-1:0]   cnt, ncnt;
  strobe_t         stb, nstb;
  logic            drive_en, ndrv;
  logic [DATA_WIDTH-1:0] wdata;
  logic            last;
  assign last       = cnt == CW'(1);
  assign req_ready  = state == IDLE;
  assign sram_notCS = stb.cs;
  assign sram_notOE = stb.oe;
  assign sram_notWE = stb.we;
  assign sram_data  = drive_en ? wdata : 'z;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      stb       <= STROBE_IDLE;
      drive_en  <= 1'b0;
      sram_addr <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      stb       <= nstb;
      drive_en  <= ndrv;
      rsp_valid <= (state == RD && last) || state == WR_HOLD;
      if (state == RD && last) rsp_rdata <= sram_data;
      if (req_valid && req_ready) begin
        sram_addr <= req_addr;
        wdata     <= req_wdata;
      end
    end
  end
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      IDLE:     if (req_valid) begin
                  nstate = req_we ? WR_SETUP : RD;
                  ncnt   = CW'(RD_WAIT_CYCLES);
                end
      RD:       if (last) nstate = IDLE; else ncnt = cnt - CW'(1);
      WR_SETUP: begin
                  nstate = WR_PULSE;
                  ncnt   = CW'(WR_PULSE_CYCLES);
                end
      WR_PULSE: if (last) nstate = WR_HOLD; else ncnt = cnt - CW'(1);
      WR_HOLD:  nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end
  // strobes are decoded from the next state so the registered pins line up with the state
  always_comb begin
    nstb = {nstate == IDLE, nstate != RD, nstate != WR_PULSE};
    ndrv = nstate inside {WR_SETUP, WR_PULSE, WR_HOLD};
  end
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: directed checks of sram_bus_ctrl against a behavioural SRAM, in two timing configurations
module tb_sram_bus_ctrl;
  logic clk = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int RDW = g == 0 ? 2 : 1;
    localparam int WRP = g == 0 ? 1 : 3;
    logic        reset, req_valid, req_ready, req_we, rsp_valid;
    logic [15:0] req_addr, req_wdata, rsp_rdata, addr;
    logic        ncs, noe, nwe;
    logic        done = 1'b0;
    wire  [15:0] data;
    logic [15:0] mem [0:65535];

    sram_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_WAIT_CYCLES(RDW), .WR_PULSE_CYCLES(WRP)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_addr(addr), .sram_data(data), .sram_notCS(ncs), .sram_notOE(noe), .sram_notWE(nwe)
    );

    assign data = (!ncs && !noe && nwe) ? mem[addr] : 'z;

    // asynchronous SRAM: commit on the rising edge of notWE, checking data/address held across the pulse
    initial begin
      logic [15:0] wd, wa;
      mem[16'h0010] = 16'hBEEF;
      forever begin
        @(negedge nwe);
        wd = data;
        wa = addr;
        @(posedge nwe);
        chk($sformatf("c%0d wr_data_stable", g), data, wd);
        chk($sformatf("c%0d wr_addr_stable", g), addr, wa);
        mem[wa] = data;
      end
    end

    always @(negedge clk) if (!reset) begin
      chk($sformatf("c%0d inv_oe_we", g), !noe && !nwe, 0);
      chk($sformatf("c%0d inv_drive_oe", g), dut.drive_en && !noe, 0);
    end

    task automatic xfer(input logic we, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp, input bit noise, input bit keep);
      int n, k, ol, wl;
      req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("c%0d accept_wait", g), n, 0);
      k = 0; ol = 0; wl = 0;
      @(negedge clk);
      while (!rsp_valid && k < 40) begin
        ol += int'(!noe); wl += int'(!nwe); k++;
        if (noise) begin
          req_valid = ~req_valid; req_addr = req_addr ^ 16'h5A5A;
          req_wdata = ~req_wdata; req_we = ~req_we;
        end else if (!keep) req_valid = 1'b0;
        @(negedge clk);
      end
      k++;
      chk($sformatf("c%0d latency %h", g, a), k, we ? WRP + 3 : RDW + 1);
      chk($sformatf("c%0d oe_low %h", g, a), ol, we ? 0 : RDW);
      chk($sformatf("c%0d we_low %h", g, a), wl, we ? WRP : 0);
      chk($sformatf("c%0d ready_at_rsp", g), req_ready, 1);
      if (!we) chk($sformatf("c%0d rdata %h", g, a), rsp_rdata, exp);
      if (!keep) req_valid = 1'b0;
    endtask

    initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk($sformatf("c%0d rst_strobes", g), {ncs, noe, nwe}, 3'b111);
      chk($sformatf("c%0d rst_drive", g), dut.drive_en, 0);
      chk($sformatf("c%0d rst_rsp", g), {rsp_valid, rsp_rdata}, 0);
      chk($sformatf("c%0d rst_addr", g), addr, 0);
      reset = 1'b0;
      @(negedge clk);
      chk($sformatf("c%0d ready_idle", g), req_ready, 1);
      xfer(0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);
      @(negedge clk);
      chk($sformatf("c%0d rsp_one_cycle", g), rsp_valid, 0);
      xfer(1, 16'h1234, 16'hA5A5, 16'h0000, 0, 0);
      xfer(0, 16'h1234, 16'h0000, 16'hA5A5, 0, 0);
      xfer(1, 16'h0000, 16'h0001, 16'h0000, 0, 1);
      xfer(1, 16'hFFFF, 16'hFFFE, 16'h0000, 0, 1);
      xfer(0, 16'h0000, 16'h0000, 16'h0001, 0, 1);
      xfer(0, 16'hFFFF, 16'h0000, 16'hFFFE, 0, 0);
      xfer(1, 16'h0042, 16'h1357, 16'h0000, 1, 0);
      xfer(0, 16'h0042, 16'h0000, 16'h1357, 1, 0);
      xfer(0, 16'h5A18, 16'h0000, 16'h0000, 0, 0);
      req_we = 1'b1; req_addr = 16'h0077; req_wdata = 16'h7777; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("c%0d setup_driving", g), {dut.drive_en, ncs}, 2'b10);
      #2 reset = 1'b1;
      #1;
      chk($sformatf("c%0d midrst_strobes", g), {ncs, noe, nwe}, 3'b111);
      chk($sformatf("c%0d midrst_drive", g), dut.drive_en, 0);
      @(negedge clk);
      reset = 1'b0;
      chk($sformatf("c%0d ready_after_rst", g), req_ready, 1);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk($sformatf("c%0d no_rsp_aborted", g), rsp_valid, 0);
      end
      xfer(0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(u[0].done && u[1].done); i++) @(negedge clk);
    chk("timeout", {u[0].done, u[1].done}, 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
